// File: rtl/dcache_line_adaptor.sv
// Memory-side responder for the dcache: moves a victim line out and/or a fill line in as
// 64-bit pmem bursts, then returns a single-cycle completion pulse with the filled line.
module dcache_line_adaptor #(
    parameter int unsigned s_offset  = 5,
    parameter int unsigned s_line    = 8 * (2 ** s_offset),
    parameter int unsigned s_beat    = 64,
    parameter int unsigned num_beats = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       req_fill_addr,
    input  logic [31:0]       req_wb_addr,
    input  logic [s_line-1:0] req_wdata,
    output logic              resp,
    output logic [s_line-1:0] resp_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_addr,
    output logic [s_beat-1:0] pmem_wdata,
    input  logic [s_beat-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned BeatW = $clog2(num_beats);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(num_beats - 1);
    localparam logic [31:0] AddrMask = ~((32'd1 << s_offset) - 32'd1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWb   = 2'd1;
    localparam logic [1:0] StFill = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BeatW-1:0]  beat_q, beat_d;
    logic              fill_pending_q, fill_pending_d;
    logic [31:0]       wb_addr_q, wb_addr_d;
    logic [31:0]       fill_addr_q, fill_addr_d;
    logic [s_line-1:0] wline_q, wline_d;
    logic [s_line-1:0] rline_q, rline_d;
    logic [s_line-1:0] resp_rdata_q, resp_rdata_d;
    logic [s_line-1:0] rline_merged;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        fill_pending_d = fill_pending_q;
        wb_addr_d      = wb_addr_q;
        fill_addr_d    = fill_addr_q;
        wline_d        = wline_q;
        rline_d        = rline_q;
        resp_rdata_d   = resp_rdata_q;
        rline_merged   = rline_q;
        rline_merged[beat_q*s_beat +: s_beat] = pmem_rdata;

        case (state_q)
            StIdle: begin
                if (req_write || req_read) begin
                    wb_addr_d      = req_wb_addr & AddrMask;
                    fill_addr_d    = req_fill_addr & AddrMask;
                    wline_d        = req_wdata;
                    fill_pending_d = req_read;
                    beat_d         = '0;
                    state_d        = req_write ? StWb : StFill;
                end
            end
            StWb: begin
                if (pmem_resp) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = fill_pending_q ? StFill : StResp;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFill: begin
                if (pmem_resp) begin
                    rline_d = rline_merged;
                    if (beat_q == LastBeat) begin
                        // Publish the whole line only once the final beat lands.
                        resp_rdata_d = rline_merged;
                        beat_d       = '0;
                        state_d      = StResp;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            fill_pending_q <= 1'b0;
            wb_addr_q      <= '0;
            fill_addr_q    <= '0;
            wline_q        <= '0;
            rline_q        <= '0;
            resp_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            fill_pending_q <= fill_pending_d;
            wb_addr_q      <= wb_addr_d;
            fill_addr_q    <= fill_addr_d;
            wline_q        <= wline_d;
            rline_q        <= rline_d;
            resp_rdata_q   <= resp_rdata_d;
        end
    end

    always_comb begin
        resp       = (state_q == StResp);
        pmem_write = (state_q == StWb);
        pmem_read  = (state_q == StFill);
        pmem_addr  = '0;
        pmem_wdata = '0;
        if (state_q == StWb) begin
            pmem_addr  = wb_addr_q;
            pmem_wdata = wline_q[beat_q*s_beat +: s_beat];
        end else if (state_q == StFill) begin
            pmem_addr = fill_addr_q;
        end
    end

    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dcache_line_adaptor.sv
// Randomized bench for dcache_line_adaptor: a pmem responder model plus an expected-line model.
module tb_dcache_line_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_read, req_write;
    logic [31:0]  req_fill_addr, req_wb_addr;
    logic [255:0] req_wdata;
    logic         resp;
    logic [255:0] resp_rdata;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_addr;
    logic [63:0]  pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    dcache_line_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_fill_addr(req_fill_addr),
        .req_wb_addr  (req_wb_addr),
        .req_wdata    (req_wdata),
        .resp         (resp),
        .resp_rdata   (resp_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr    (pmem_addr),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Responder / reference state
    bit           exp_rd, exp_wr, stray;
    int           period = 1;
    int           stall_cnt, wr_beat, rd_beat;
    logic [31:0]  exp_fill_addr, exp_wb_addr;
    logic [255:0] exp_wline, fill_line, exp_line_model;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    always @(negedge clk) begin
        pmem_resp = 1'b0;
        if (stray) begin
            pmem_resp = 1'b1;
        end else if (pmem_read || pmem_write) begin
            if (pmem_read && pmem_write) check_eq("strobe_overlap", 1, 0);
            if (pmem_write && !exp_wr) check_eq("unexpected_write", 1, 0);
            if (pmem_read && !exp_rd) check_eq("unexpected_read", 1, 0);
            stall_cnt++;
            if (stall_cnt % period == 0) begin
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    check_eq("wb_addr", pmem_addr, exp_wb_addr);
                    if (wr_beat < 4) check_eq("wb_beat", pmem_wdata, exp_wline[wr_beat*64 +: 64]);
                    else check_eq("wb_extra_beat", 1, 0);
                    wr_beat++;
                end else begin
                    check_eq("fill_addr", pmem_addr, exp_fill_addr);
                    check_eq("fill_after_wb", wr_beat, exp_wr ? 4 : 0);
                    pmem_rdata = (rd_beat < 4) ? fill_line[rd_beat*64 +: 64] : 64'hdead;
                    rd_beat++;
                end
            end
        end
    end

    task automatic setup_txn(input bit rd, input bit wr, input logic [31:0] fa,
                             input logic [31:0] wa, input int per);
        exp_rd        = rd;
        exp_wr        = wr;
        exp_fill_addr = {fa[31:5], 5'b0};
        exp_wb_addr   = {wa[31:5], 5'b0};
        exp_wline     = rand_line();
        fill_line     = rand_line();
        wr_beat       = 0;
        rd_beat       = 0;
        stall_cnt     = 0;
        period        = per;
        req_read      = rd;
        req_write     = wr;
        req_fill_addr = fa;
        req_wb_addr   = wa;
        req_wdata     = exp_wline;
    endtask

    // exp_lat = 0 skips the latency check (stalled bursts)
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] fa,
                           input logic [31:0] wa, input int per, input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        setup_txn(rd, wr, fa, wa, per);
        lat = 0;
        got = 0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (resp) got = 1;
        end
        check_eq("resp_seen", got, 1);
        if (exp_lat > 0) check_eq("latency", lat, exp_lat);
        if (rd) exp_line_model = fill_line;
        check_eq("resp_rdata", resp_rdata, exp_line_model);
        check_eq("wr_beats", wr_beat, wr ? 4 : 0);
        check_eq("rd_beats", rd_beat, rd ? 4 : 0);
        req_read  = 1'b0;
        req_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("no_extra_resp", resp, 0);
            check_eq("idle_strobes", {pmem_read, pmem_write}, 0);
        end
        check_eq("rdata_held", resp_rdata, exp_line_model);
        exp_rd = 0;
        exp_wr = 0;
    endtask

    initial begin
        bit rd, wr;
        int per, guard;
        rst = 1'b1;
        req_read = 0; req_write = 0; req_fill_addr = 0; req_wb_addr = 0; req_wdata = 0;
        pmem_rdata = 0; pmem_resp = 0; stray = 0; exp_rd = 0; exp_wr = 0;
        exp_line_model = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", {resp, pmem_read, pmem_write}, 0);
        check_eq("rst_addr", pmem_addr, 0);
        check_eq("rst_wdata", pmem_wdata, 0);
        check_eq("rst_rdata", resp_rdata, 0);
        rst = 1'b0;

        run_txn(1, 0, 32'h0000_1234, 32'h0, 1, 5);       // fill only
        run_txn(0, 1, 32'h0, 32'h8000_00E0, 1, 5);       // writeback only
        run_txn(1, 1, 32'h0000_0080, 32'h0000_0040, 1, 9); // wb + fill
        run_txn(1, 0, 32'h0000_3F1C, 32'h0, 3, 0);       // stalled fill

        // Stray pmem_resp while idle must be ignored
        @(negedge clk);
        stray = 1;
        repeat (3) begin
            @(negedge clk);
            check_eq("stray_strobes", {resp, pmem_read, pmem_write}, 0);
        end
        stray = 0;
        check_eq("stray_rdata", resp_rdata, exp_line_model);
        run_txn(1, 0, 32'h0000_5550, 32'h0, 1, 5);

        // Reset after beat 2 of a writeback
        @(negedge clk);
        setup_txn(0, 1, 32'h0, 32'h0000_0A00, 1);
        guard = 0;
        while (wr_beat < 2 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        check_eq("mid_wb_reached", wr_beat, 2);
        period = 1000;
        @(negedge clk);
        rst = 1'b1;
        req_write = 1'b0;
        @(negedge clk);
        check_eq("abort_strobes", {resp, pmem_read, pmem_write}, 0);
        check_eq("abort_addr", pmem_addr, 0);
        exp_line_model = '0;
        check_eq("abort_rdata", resp_rdata, exp_line_model);
        rst = 1'b0;
        exp_wr = 0;
        run_txn(1, 0, 32'h0000_7777, 32'h0, 1, 5);

        for (int i = 0; i < 10; i++) begin
            rd  = $urandom_range(0, 1);
            wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            per = $urandom_range(1, 3);
            run_txn(rd, wr, $urandom, $urandom, per, (per == 1) ? ((rd && wr) ? 9 : 5) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
